// File: rtl/sort_network_seq.sv
// sort_network_seq: sequential odd-even transposition sorter.
// The block runs one compare/swap phase per clock behind a four-phase req/fin handshake.
// It supports ascending or descending order and signed or unsigned compare.
// It exits early after two consecutive swap-free phases and counts the swaps it performs.
module sort_network_seq #(
    parameter int Width  = 32,
    parameter int Depth  = 8,
    parameter bit Signed = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req,
    output logic                                   fin,
    input  logic                                   descend,
    input  logic [Width*Depth-1:0]                 data_in,
    output logic [Width*Depth-1:0]                 data_out,
    output logic [$clog2(Depth*(Depth-1)/2+1)-1:0] swap_count,
    output logic                                   busy
);
    localparam int CW = $clog2(Depth*(Depth-1)/2+1);
    localparam int SW = CW + 1;
    localparam int PW = $clog2(Depth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [Width*Depth-1:0] elem_reg, elem_next;
    logic                   descend_reg;
    logic [PW-1:0]          phase_reg;
    logic                   prev_zero_reg;
    logic [CW-1:0]          swap_count_reg, swap_count_next;
    logic [Depth-2:0]       pair_swap;
    logic [SW-1:0]          phase_swaps, swap_sum;
    logic                   phase_zero, last_phase, early_exit;

    // One comparator per adjacent pair.
    // A pair is active only in phases whose parity matches the pair's lower index.
    genvar gi;
    generate
        for (gi = 0; gi < Depth - 1; gi++) begin : g_pair
            localparam bit ODD_PAIR = (gi % 2) == 1;
            logic [Width-1:0] lo_elem, hi_elem;
            logic             lo_gt_hi, lo_lt_hi;

            assign lo_elem = elem_reg[gi*Width +: Width];
            assign hi_elem = elem_reg[(gi+1)*Width +: Width];

            if (Signed) begin : g_signed
                assign lo_gt_hi = $signed(lo_elem) > $signed(hi_elem);
                assign lo_lt_hi = $signed(lo_elem) < $signed(hi_elem);
            end else begin : g_unsigned
                assign lo_gt_hi = lo_elem > hi_elem;
                assign lo_lt_hi = lo_elem < hi_elem;
            end

            // Strict compares: equal values never swap, which keeps the sort stable.
            assign pair_swap[gi] = (phase_reg[0] == ODD_PAIR) &&
                                   (descend_reg ? lo_lt_hi : lo_gt_hi);
        end
    endgenerate

    // Apply this phase's swaps and count them.
    // The active pairs are disjoint, so each element moves at most once.
    always_comb begin
        elem_next   = elem_reg;
        phase_swaps = '0;
        for (int j = 0; j < Depth - 1; j++) begin
            if (pair_swap[j]) begin
                elem_next[j*Width +: Width]     = elem_reg[(j+1)*Width +: Width];
                elem_next[(j+1)*Width +: Width] = elem_reg[j*Width +: Width];
            end
            phase_swaps = phase_swaps + SW'(pair_swap[j]);
        end
    end

    assign phase_zero      = (pair_swap == '0);
    assign last_phase      = (phase_reg == PW'(Depth - 1));
    assign early_exit      = (phase_reg != '0) && prev_zero_reg && phase_zero;
    assign swap_sum        = {1'b0, swap_count_reg} + phase_swaps;
    assign swap_count_next = swap_sum[CW] ? {CW{1'b1}} : swap_sum[CW-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the IDLE -> SORT -> DONE -> IDLE handshake
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = SORT;
            SORT:    if (last_phase || early_exit) state_next = DONE;
            DONE:    if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Element array, mode latch, phase counter and swap counter.
    // Data is captured on a request in IDLE and then advanced one phase per clock in SORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_reg       <= '0;
            descend_reg    <= 1'b0;
            phase_reg      <= '0;
            prev_zero_reg  <= 1'b0;
            swap_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        elem_reg       <= data_in;
                        descend_reg    <= descend;
                        phase_reg      <= '0;
                        prev_zero_reg  <= 1'b0;
                        swap_count_reg <= '0;
                    end
                end
                SORT: begin
                    elem_reg       <= elem_next;
                    swap_count_reg <= swap_count_next;
                    phase_reg      <= phase_reg + 1'b1;
                    prev_zero_reg  <= phase_zero;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out   = elem_reg;
    assign swap_count = swap_count_reg;
    assign fin        = (state_reg == DONE);
    assign busy       = (state_reg == SORT);

endmodule

// File: tb/tb_sort_network_seq.sv
// Self-checking bench for sort_network_seq.
// Three instances share one stimulus stream: Depth 4 unsigned, Depth 4 signed and Depth 5 signed.
// Expected results come from a reference model and are queued at issue time.
// A monitor pops and compares them whenever an instance raises fin.
`timescale 1ns/1ps
module tb_sort_network_seq;
    typedef struct {
        logic [39:0] data;
        int          swaps;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, req, descend;
    logic [39:0] data_in;

    logic [31:0] dout0, dout1;
    logic [39:0] dout2;
    logic [2:0]  sc0, sc1;
    logic [3:0]  sc2;
    logic        fin0, fin1, fin2, busy0, busy1, busy2;

    logic [39:0] dout_w [3];
    logic [3:0]  sc_w   [3];
    logic        fin_w  [3];
    logic        busy_w [3];

    int checks = 0;
    int errors = 0;

    exp_t q0[$], q1[$], q2[$];
    logic [39:0] exp_data  [3];
    int          exp_swaps [3];
    int          busy_cnt  [3];
    bit          prev_fin  [3];
    int          last_lat  [3];

    always #5 clk = ~clk;

    sort_network_seq #(.Width(8), .Depth(4), .Signed(1'b0)) u_d4u (
        .clk(clk), .rst_n(rst_n), .req(req), .fin(fin0), .descend(descend),
        .data_in(data_in[31:0]), .data_out(dout0), .swap_count(sc0), .busy(busy0));
    sort_network_seq #(.Width(8), .Depth(4), .Signed(1'b1)) u_d4s (
        .clk(clk), .rst_n(rst_n), .req(req), .fin(fin1), .descend(descend),
        .data_in(data_in[31:0]), .data_out(dout1), .swap_count(sc1), .busy(busy1));
    sort_network_seq #(.Width(8), .Depth(5), .Signed(1'b1)) u_d5s (
        .clk(clk), .rst_n(rst_n), .req(req), .fin(fin2), .descend(descend),
        .data_in(data_in), .data_out(dout2), .swap_count(sc2), .busy(busy2));

    assign dout_w[0] = {8'h00, dout0};
    assign dout_w[1] = {8'h00, dout1};
    assign dout_w[2] = dout2;
    assign sc_w[0]   = {1'b0, sc0};
    assign sc_w[1]   = {1'b0, sc1};
    assign sc_w[2]   = sc2;
    assign fin_w[0]  = fin0;
    assign fin_w[1]  = fin1;
    assign fin_w[2]  = fin2;
    assign busy_w[0] = busy0;
    assign busy_w[1] = busy1;
    assign busy_w[2] = busy2;

    function automatic int depth_of(input int i);
        return (i == 2) ? 5 : 4;
    endfunction

    function automatic bit sgn_of(input int i);
        return i != 0;
    endfunction

    // Decide whether a pair is out of order for the requested direction.
    function automatic bit out_of_order(input int x, input int y, input bit desc);
        return desc ? (x < y) : (x > y);
    endfunction

    // Reference model.
    // The result is a stable insertion sort.
    // The swap count equals the number of inversions.
    // The latency comes from playing the transposition phases until the exit rule fires.
    function automatic exp_t model(input int depth, input bit sgn, input bit desc,
                                   input logic [39:0] din);
        exp_t        r;
        logic [7:0]  b [5];
        int          v [5];
        int          ord [5];
        int          a [5];
        int          t, k;
        bit          zero, prev_zero, done;
        for (int i = 0; i < depth; i++) begin
            b[i]   = din[i*8 +: 8];
            v[i]   = sgn ? int'($signed(b[i])) : int'(b[i]);
            ord[i] = i;
            a[i]   = v[i];
        end
        r.swaps = 0;
        for (int i = 0; i < depth; i++)
            for (int j = i + 1; j < depth; j++)
                if (out_of_order(v[i], v[j], desc)) r.swaps++;
        for (int i = 1; i < depth; i++) begin
            k = i;
            while (k > 0 && out_of_order(v[ord[k-1]], v[ord[k]], desc)) begin
                t = ord[k]; ord[k] = ord[k-1]; ord[k-1] = t;
                k--;
            end
        end
        r.data = '0;
        for (int i = 0; i < depth; i++) r.data[i*8 +: 8] = b[ord[i]];
        r.lat = depth;
        prev_zero = 1'b0;
        done = 1'b0;
        for (int p = 0; p < depth; p++) begin
            if (!done) begin
                zero = 1'b1;
                for (int j = p % 2; j + 1 < depth; j += 2) begin
                    if (out_of_order(a[j], a[j+1], desc)) begin
                        t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                        zero = 1'b0;
                    end
                end
                if (p >= 1 && prev_zero && zero) begin
                    r.lat = p + 1;
                    done  = 1'b1;
                end
                prev_zero = zero;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int i, output exp_t e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Monitor: at every negedge, count busy cycles and check each fin rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    busy_cnt[i] = 0;
                    prev_fin[i] = 1'b0;
                end else begin
                    if (busy_w[i]) busy_cnt[i]++;
                    if (fin_w[i] && !prev_fin[i]) begin
                        if (qsize(i) == 0) begin
                            chk("unexpected_fin", i, 64'(fin_w[i]), 64'd0);
                        end else begin
                            pop_exp(i, e);
                            chk("data_out", i, 64'(dout_w[i]), 64'(e.data));
                            chk("swap_count", i, 64'(sc_w[i]), 64'(e.swaps));
                            chk("busy_cycles", i, 64'(busy_cnt[i]), 64'(e.lat));
                            $display("dut%0d result data=%h swaps=%0d cycles=%0d",
                                     i, dout_w[i], sc_w[i], busy_cnt[i]);
                        end
                        last_lat[i] = busy_cnt[i];
                        busy_cnt[i] = 0;
                    end
                    prev_fin[i] = fin_w[i];
                end
            end
        end
    end

    // Issue a request and queue the model's expectation for each instance.
    // The task returns just after the capture edge.
    task automatic start_job(input logic [39:0] d, input bit desc);
        exp_t e;
        @(negedge clk);
        data_in = d;
        descend = desc;
        req     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = model(depth_of(i), sgn_of(i), desc, d);
            push_exp(i, e);
            exp_data[i]  = e.data;
            exp_swaps[i] = e.swaps;
        end
        @(posedge clk);
    endtask

    // Wait, with a bound, until every instance shows fin.
    // The inputs are scrambled meanwhile to prove they are ignored.
    task automatic wait_all_fin();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (fin_w[0] && fin_w[1] && fin_w[2]) break;
            data_in = {8'($urandom), 32'($urandom)};
            descend = 1'($urandom_range(0, 1));
            n++;
            if (n > 20) begin
                chk("fin_timeout", 0, 64'd0, 64'd1);
                break;
            end
        end
    endtask

    // Hold req high for some cycles and check fin, data_out and swap_count stay put.
    // Then drop req and check fin falls at the next edge.
    task automatic finish_job(input int hold);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("hold_fin", i, 64'(fin_w[i]), 64'd1);
                chk("hold_data", i, 64'(dout_w[i]), 64'(exp_data[i]));
                chk("hold_swaps", i, 64'(sc_w[i]), 64'(exp_swaps[i]));
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("fin_drop", i, 64'(fin_w[i]), 64'd0);
    endtask

    // Protocol violation: req falls during SORT.
    // The sort still completes, and the monitor checks the one-cycle fin pulse.
    task automatic drop_job(input logic [39:0] d, input bit desc);
        start_job(d, desc);
        @(negedge clk);
        req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            data_in = {8'($urandom), 32'($urandom)};
        end
        for (int i = 0; i < 3; i++) begin
            chk("drop_fin_idle", i, 64'(fin_w[i]), 64'd0);
            chk("drop_busy_idle", i, 64'(busy_w[i]), 64'd0);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_fin"}, i, 64'(fin_w[i]), 64'd0);
            chk({tag, "_busy"}, i, 64'(busy_w[i]), 64'd0);
            chk({tag, "_swaps"}, i, 64'(sc_w[i]), 64'd0);
            chk({tag, "_data"}, i, 64'(dout_w[i]), 64'd0);
        end
    endtask

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        logic [39:0] d;
        bit          desc;
        rst_n   = 1'b1;
        req     = 1'b0;
        descend = 1'b0;
        data_in = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;

        // Elements [3,1,2,0] ascending: full latency, 5 swaps.
        start_job(40'h00_00020103, 1'b0);
        wait_all_fin();
        #1;
        chk("asc_data", 0, 64'(dout_w[0]), 64'h03020100);
        chk("asc_swaps", 0, 64'(sc_w[0]), 64'd5);
        chk("asc_latency", 0, 64'(last_lat[0]), 64'd4);
        finish_job(0);

        // An already sorted input exits early after 2 cycles.
        start_job(40'h00_03020100, 1'b0);
        wait_all_fin();
        #1;
        chk("sorted_data", 0, 64'(dout_w[0]), 64'h03020100);
        chk("sorted_swaps", 0, 64'(sc_w[0]), 64'd0);
        chk("sorted_latency", 0, 64'(last_lat[0]), 64'd2);
        finish_job(0);

        // Descending [1,4,4,2]: equal values stay put, so the swap count is 3.
        start_job(40'h00_02040401, 1'b1);
        wait_all_fin();
        #1;
        chk("desc_data", 0, 64'(dout_w[0]), 64'h01020404);
        chk("desc_swaps", 0, 64'(sc_w[0]), 64'd3);
        finish_job(0);

        // Signed versus unsigned on [0x7F,0x80,0x00,0xFF], then hold req for 5 cycles.
        start_job(40'h00_FF00807F, 1'b0);
        wait_all_fin();
        #1;
        chk("unsigned_data", 0, 64'(dout_w[0]), 64'hFF807F00);
        chk("signed_data", 1, 64'(dout_w[1]), 64'h7F00FF80);
        finish_job(5);

        // Reset asserted while phase 2 is pending.
        start_job(40'h0102030405, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("busy_before_reset", i, 64'(busy_w[i]), 64'd1);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk_reset_values("midsort_reset");
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random jobs: 1000 per direction, with occasional early req drops.
        for (int n = 0; n < 2000; n++) begin
            d    = {8'($urandom), 32'($urandom)};
            desc = n[0];
            if ($urandom_range(0, 3) == 0) d = d & 40'h0303030303;
            if ($urandom_range(0, 9) == 0) begin
                drop_job(d, desc);
            end else begin
                start_job(d, desc);
                wait_all_fin();
                finish_job(int'($urandom_range(0, 2)));
            end
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("queue_drained", i, 64'(qsize(i)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_network_seq.md
Name: sort_network_seq

Overview:
- Parametrised, clocked successor of the two-input compare/swap element.
- Sorts Depth words of Width bits with odd-even transposition, one compare/swap phase per clock, behind the team's req/fin four-phase handshake.
- Adds ascending/descending mode, signed/unsigned compare, an early-exit test and a swap counter.
- Sits in the flow-control library as the sort stage feeding median/selection blocks.

Parameters:
- Width, 32: bits per element.
- Depth, 8: number of elements, minimum 2, any integer (odd allowed).
- Signed, 0: 1 = two's-complement compare; 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  start request, four-phase handshake.
- fin  output  1  result valid / handshake acknowledge.
- descend  input  1  0 = ascending, 1 = descending; sampled with data_in.
- data_in  input  Width*Depth  element i = data_in[i*Width +: Width].
- data_out  output  Width*Depth  sorted result, same packing; element 0 = min (ascending) or max (descending).
- swap_count  output  $clog2(Depth*(Depth-1)/2+1)  swaps performed in the current/last sort.
- busy  output  1  high while in SORT.

Behaviour:
- Reset (async assert, sync release): state IDLE; fin=0, busy=0, swap_count=0, data_out=0, phase counter=0.
- FSM: IDLE -> SORT -> DONE -> IDLE.
- IDLE:
  - At an edge with req=1: capture data_in into the element registers and latch descend; clear swap_count and the phase counter.
  - Go to SORT.
- SORT, one phase per edge, phase p = 0..Depth-1:
  - Even p compares pairs (0,1),(2,3),...; odd p compares pairs (1,2),(3,4),...
  - Unpaired end element holds.
  - Ascending: swap when elem[j] > elem[j+1]. Descending: swap when elem[j] < elem[j+1].
  - Equal elements never swap (sort is stable).
  - swap_count += number of swaps in the phase; saturates, though it cannot exceed the inversion count.
- Exit from SORT:
  - Normal: after phase Depth-1, go to DONE.
  - Early: after phase p>=1, if phases p-1 and p both performed zero swaps, go to DONE at that edge.
  - Worst-case latency: fin rises Depth cycles after the req-capture edge. Best case: 2 cycles.
- DONE:
  - fin=1; data_out and swap_count held stable.
  - Stays in DONE while req=1.
  - First edge sampling req=0: fin->0, go to IDLE.
  - A new sort needs req to go high again from IDLE, so at least one cycle with req=0 between jobs.
- busy=1 exactly while in SORT. fin is registered, with no combinational path from req.
- data_out mirrors the element registers continuously. It is only guaranteed sorted while fin=1.
- data_in and descend changes after the capture edge are ignored.
- req dropping during SORT (protocol violation): the sort completes; fin is high for exactly one cycle, then the block returns to IDLE.
- rst_n low at any time, including mid-sort: immediate return to the reset values above; the in-flight sort is discarded.
- Signed=1: compare as signed Width-bit values. Signed=0: compare unsigned.

Test Plan:
- Depth=4, Width=8, ascending, elements [3,1,2,0] (element 0 first), pulse req -> fin after 4 cycles; data_out=[0,1,2,3]; swap_count=5; busy high 4 cycles.
- Same config, input already sorted [0,1,2,3] -> early exit, fin after 2 cycles; swap_count=0; data_out unchanged.
- descend=1, input [1,4,4,2] -> data_out=[4,4,2,1]; the two 4s keep their original order (tag via a debug bit in a wider-Width variant); swap_count=3.
- Signed=1, Width=8, input [0x7F,0x80,0x00,0xFF] -> data_out=[0x80,0xFF,0x00,0x7F]. Same input with Signed=0 -> [0x00,0x7F,0x80,0xFF].
- req held high 5 cycles after fin -> fin and data_out stable, no restart. req low -> fin=0 next edge. data_in changed mid-sort -> no effect on the result.
- Depth=5 random vectors, rst_n pulsed low during phase 2 -> all outputs 0 immediately, IDLE. A following req sorts the new data correctly; compare against a reference model over 1000 random runs per mode.
